// File: rtl/mult_div_unit_pkg.sv
// mult_div_unit_pkg
//   Shared definitions for the iterative multiply/divide unit: op encodings
//   as presented on the op port, FSM state encodings and small op-decode
//   helpers.
package mult_div_unit_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  localparam int unsigned MD_ITERS = 32;

  function automatic logic md_is_signed(input logic [1:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic md_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// mult_div_unit
//   Iterative 32-bit MULT/MULTU/DIV/DIVU unit with architectural HI/LO.
//   Operand magnitudes are latched on start, 32 iterations run one per
//   clock (shift-add or restoring shift-subtract), then a FIX cycle applies
//   sign correction and writes HI/LO. Latency start->done is 33 clocks.
//
// Ports
//   clock        system clock, rising edge
//   reset        synchronous, active-high
//   start        request, sampled only while busy=0
//   op           00 MULT, 01 MULTU, 10 DIV, 11 DIVU (latched with start)
//   a, b         operands (multiplicand/dividend, multiplier/divisor)
//   busy         operation in progress (registered)
//   done         one-cycle pulse, HI/LO updated on the same edge
//   div_by_zero  one-cycle pulse with done for DIV/DIVU with b=0
//   hi, lo       HI/LO registers
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for start; HI/LO hold
// RUN     | one shift-add / shift-subtract iteration per clock (32)
// FIX     | sign correction / divide-by-zero override, write HI/LO
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [1:0]         state;
  logic [5:0]         iter;
  logic               is_div;
  logic               neg_main;   // negate product / quotient
  logic               neg_rem;    // remainder takes dividend sign
  logic               bzero;
  logic [WIDTH-1:0]   a_orig;
  // multiplicand for MULT*, divisor for DIV*
  logic [WIDTH-1:0]   opnd;
  // {acc, multiplier} for MULT*, {rem, quot/dividend} for DIV*
  logic [2*WIDTH-1:0] work;

  logic               op_signed;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_next;

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_comb begin
    op_signed = md_is_signed(op);
    a_neg     = op_signed & a[WIDTH-1];
    b_neg     = op_signed & b[WIDTH-1];
    // -0x80000000 wraps to itself, which is the correct unsigned magnitude
    a_mag     = a_neg ? -a : a;
    b_mag     = b_neg ? -b : b;
  end

  // Shift-add: the carry out of the add becomes the new top bit after the shift.
  always_comb begin
    mul_sum  = {1'b0, work[2*WIDTH-1:WIDTH]} + (work[0] ? {1'b0, opnd} : '0);
    mul_next = {mul_sum, work[WIDTH-1:1]};
  end

  // Restoring divide: partial remainder stays below the divisor, so the
  // shifted remainder fits in WIDTH+1 bits and the result in WIDTH bits.
  always_comb begin
    rem_sh   = work[2*WIDTH-1:WIDTH-1];
    div_ge   = (rem_sh >= {1'b0, opnd});
    div_diff = rem_sh - {1'b0, opnd};
    div_next = div_ge ? {div_diff[WIDTH-1:0], work[WIDTH-2:0], 1'b1}
                      : {rem_sh[WIDTH-1:0],   work[WIDTH-2:0], 1'b0};
  end

  always_comb begin
    prod_fix = neg_main ? -work : work;
    quot_fix = neg_main ? -work[WIDTH-1:0] : work[WIDTH-1:0];
    rem_fix  = neg_rem  ? -work[2*WIDTH-1:WIDTH] : work[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      iter        <= '0;
      is_div      <= 1'b0;
      neg_main    <= 1'b0;
      neg_rem     <= 1'b0;
      bzero       <= 1'b0;
      a_orig      <= '0;
      opnd        <= '0;
      work        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            is_div   <= md_is_div(op);
            neg_main <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            bzero    <= (b == '0);
            a_orig   <= a;
            iter     <= '0;
            busy     <= 1'b1;
            state    <= ST_RUN;
            if (md_is_div(op)) begin
              opnd <= b_mag;
              work <= {{WIDTH{1'b0}}, a_mag};
            end else begin
              opnd <= a_mag;
              work <= {{WIDTH{1'b0}}, b_mag};
            end
          end
        end
        ST_RUN: begin
          work <= is_div ? div_next : mul_next;
          if (iter == 6'(MD_ITERS - 1)) begin
            state <= ST_FIX;
          end else begin
            iter <= iter + 6'd1;
          end
        end
        ST_FIX: begin
          if (is_div) begin
            if (bzero) begin
              hi          <= a_orig;
              lo          <= '1;
              div_by_zero <= 1'b1;
            end else begin
              hi <= rem_fix;
              lo <= quot_fix;
            end
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit
//   Directed vector table for all four ops plus hand-written sequences for
//   start-while-busy, back-to-back start in the done cycle and mid-op reset.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_fail   = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called away from a clock edge; returns #1 after the start edge E0.
  task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    // operands changing after E0 must have no effect
    op    = ~o;
    a     = 32'hDEADBEEF;
    b     = 32'h00000000;
  endtask

  // Counts edges after E0 until done. busy must stay high and done/dbz low
  // before the done cycle. inj>0 pulses a competing start after edge inj.
  task automatic wait_done(input int inj, output int lat, output logic bad);
    lat = -1;
    bad = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clock);
      #1;
      if (k == inj) begin
        start = 1'b1;
        op    = MD_MULT;
        a     = 32'd9;
        b     = 32'd9;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        lat = k;
        if (busy !== 1'b0) bad = 1'b1;
        break;
      end
      if (busy !== 1'b1 || div_by_zero !== 1'b0) bad = 1'b1;
    end
    start = 1'b0;
  endtask

  initial begin
    int   lat;
    logic bad;

    vecs[0]  = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[1]  = '{MD_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[2]  = '{MD_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
    vecs[3]  = '{MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[4]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[5]  = '{MD_DIV,   32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF, 1'b1};
    vecs[6]  = '{MD_DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1};
    vecs[7]  = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[8]  = '{MD_MULT,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001, 1'b0};
    vecs[9]  = '{MD_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
    vecs[10] = '{MD_MULTU, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780, 1'b0};
    vecs[11] = '{MD_DIVU,  32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF, 1'b0};
    vecs[12] = '{MD_DIV,   32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1};

    reset = 1'b1;
    start = 1'b0;
    op    = '0;
    a     = '0;
    b     = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_dbz",  32'(div_by_zero), 32'd0);
    check("reset_hi",   hi, 32'd0);
    check("reset_lo",   lo, 32'd0);
    reset = 1'b0;
    @(posedge clock);
    #1;

    for (int i = 0; i < 13; i++) begin
      start_op(vecs[i].op, vecs[i].a, vecs[i].b);
      check($sformatf("v%0d_busy_e0", i), 32'(busy), 32'd1);
      wait_done(0, lat, bad);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'd33);
      check($sformatf("v%0d_busy_window", i), 32'(bad), 32'd0);
      check($sformatf("v%0d_hi", i), hi, vecs[i].hi);
      check($sformatf("v%0d_lo", i), lo, vecs[i].lo);
      check($sformatf("v%0d_dbz", i), 32'(div_by_zero), 32'(vecs[i].dbz));
      @(posedge clock);
      #1;
      check($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
      check($sformatf("v%0d_dbz_pulse", i), 32'(div_by_zero), 32'd0);
      check($sformatf("v%0d_hold_hi", i), hi, vecs[i].hi);
      check($sformatf("v%0d_hold_lo", i), lo, vecs[i].lo);
    end

    // start while busy is ignored; start in the done cycle is accepted
    start_op(MD_MULTU, 32'd3, 32'd5);
    wait_done(5, lat, bad);
    check("ign_latency", 32'(lat), 32'd33);
    check("ign_busy_window", 32'(bad), 32'd0);
    check("ign_hi", hi, 32'd0);
    check("ign_lo", lo, 32'd15);
    start_op(MD_DIVU, 32'd100, 32'd7);
    check("b2b_accepted", 32'(busy), 32'd1);
    check("b2b_old_lo", lo, 32'd15);
    wait_done(0, lat, bad);
    check("b2b_latency", 32'(lat), 32'd33);
    check("b2b_hi", hi, 32'd2);
    check("b2b_lo", lo, 32'd14);
    @(posedge clock);
    #1;

    // reset sampled at E10 of a MULTU aborts it
    start_op(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (9) @(posedge clock);
    #1;
    check("pre_rst_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    bad = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clock);
      #1;
      if (done !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    check("rst_no_done", 32'(bad), 32'd0);
    start_op(MD_MULTU, 32'd3, 32'd5);
    wait_done(0, lat, bad);
    check("post_rst_latency", 32'(lat), 32'd33);
    check("post_rst_hi", hi, 32'd0);
    check("post_rst_lo", lo, 32'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
